// File: rtl/systolic_array_stream.sv
// Output-stationary MAX_DIM x MAX_DIM systolic MAC array with an internal operand skew network,
// valid/ready step intake, a runtime dimension and optional saturating accumulation.
module systolic_array_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int BUS_WIDTH  = 64,
  parameter int SATURATE   = 0,
  localparam int MAX_DIM   = BUS_WIDTH / DATA_WIDTH,
  localparam int DIM_W     = $clog2(MAX_DIM) + 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 start_i,
  input  logic [DIM_W-1:0]                     dim_i,
  input  logic [MAX_DIM*DATA_WIDTH-1:0]        a_col_i,
  input  logic [MAX_DIM*DATA_WIDTH-1:0]        b_row_i,
  input  logic                                 valid_i,
  output logic                                 ready_o,
  output logic [BUS_WIDTH*MAX_DIM*MAX_DIM-1:0] mul_o,
  output logic [MAX_DIM*MAX_DIM-1:0]           flags_o,
  output logic                                 busy_o,
  output logic                                 finish_o
);
  localparam int CNT_W = DIM_W + 1;
  localparam logic signed [BUS_WIDTH-1:0] ACC_MAX = {1'b0, {(BUS_WIDTH-1){1'b1}}};
  localparam logic signed [BUS_WIDTH-1:0] ACC_MIN = {1'b1, {(BUS_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t             state_q;
  logic [DIM_W-1:0]   n_q;
  logic [DIM_W-1:0]   k_q;
  logic [CNT_W-1:0]   drain_q;
  logic [MAX_DIM-1:0] lane_en;
  logic               vld_p0;

  logic signed [DATA_WIDTH-1:0] a_skew_p0 [MAX_DIM][MAX_DIM];
  logic signed [DATA_WIDTH-1:0] b_skew_p0 [MAX_DIM][MAX_DIM];
  logic signed [DATA_WIDTH-1:0] a_in      [MAX_DIM][MAX_DIM];
  logic signed [DATA_WIDTH-1:0] b_in      [MAX_DIM][MAX_DIM];
  logic signed [DATA_WIDTH-1:0] a_pe_p1   [MAX_DIM][MAX_DIM];
  logic signed [DATA_WIDTH-1:0] b_pe_p1   [MAX_DIM][MAX_DIM];
  logic signed [BUS_WIDTH-1:0]  acc_p1    [MAX_DIM][MAX_DIM];
  logic signed [BUS_WIDTH-1:0]  sum_c     [MAX_DIM][MAX_DIM];
  logic                         ovf_c     [MAX_DIM][MAX_DIM];
  logic                         flag_q    [MAX_DIM][MAX_DIM];

  function automatic logic [DIM_W-1:0] dim_clamp(input logic [DIM_W-1:0] d);
    return (d == '0 || d > DIM_W'(MAX_DIM)) ? DIM_W'(MAX_DIM) : d;
  endfunction

  // Returns {overflow, next accumulator}; product is sign-extended before the add.
  function automatic logic [BUS_WIDTH:0] mac_add(input logic signed [BUS_WIDTH-1:0]  acc,
                                                 input logic signed [DATA_WIDTH-1:0] a,
                                                 input logic signed [DATA_WIDTH-1:0] b);
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [BUS_WIDTH-1:0]    ext;
    logic signed [BUS_WIDTH-1:0]    sum;
    logic                           ovf;
    prod = (2*DATA_WIDTH)'(a) * (2*DATA_WIDTH)'(b);
    ext  = BUS_WIDTH'(prod);
    sum  = acc + ext;
    ovf  = (acc[BUS_WIDTH-1] == ext[BUS_WIDTH-1]) && (sum[BUS_WIDTH-1] != acc[BUS_WIDTH-1]);
    if (SATURATE != 0 && ovf) sum = acc[BUS_WIDTH-1] ? ACC_MIN : ACC_MAX;
    return {ovf, sum};
  endfunction

  // A restart cycle never takes a step, even with valid_i high.
  assign vld_p0 = valid_i & ready_o & ~start_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      n_q      <= DIM_W'(MAX_DIM);
      k_q      <= '0;
      drain_q  <= '0;
      ready_o  <= 1'b0;
      busy_o   <= 1'b0;
      finish_o <= 1'b0;
    end else begin
      finish_o <= 1'b0;
      if (start_i) begin
        state_q <= FEED;
        n_q     <= dim_clamp(dim_i);
        k_q     <= '0;
        drain_q <= '0;
        ready_o <= 1'b1;
        busy_o  <= 1'b1;
      end else begin
        unique case (state_q)
          FEED: if (vld_p0) begin
            if (k_q == n_q - DIM_W'(1)) begin
              state_q <= DRAIN;
              ready_o <= 1'b0;
            end else begin
              k_q <= k_q + DIM_W'(1);
            end
          end
          DRAIN: if (drain_q == {n_q, 1'b0} - CNT_W'(2)) begin
            state_q <= DONE;
            busy_o  <= 1'b0;
          end else begin
            drain_q <= drain_q + CNT_W'(1);
          end
          // finish is registered off DONE so it lands after the last PE has settled.
          DONE: begin
            state_q  <= IDLE;
            finish_o <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Stage p0: injection and skew; stage p1: PE operand hops and accumulators.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MAX_DIM; i++) begin
        for (int j = 0; j < MAX_DIM; j++) begin
          a_skew_p0[i][j] <= '0;
          b_skew_p0[i][j] <= '0;
          a_pe_p1[i][j]   <= '0;
          b_pe_p1[i][j]   <= '0;
          acc_p1[i][j]    <= '0;
          flag_q[i][j]    <= 1'b0;
        end
      end
    end else if (start_i) begin
      for (int i = 0; i < MAX_DIM; i++) begin
        for (int j = 0; j < MAX_DIM; j++) begin
          a_skew_p0[i][j] <= '0;
          b_skew_p0[i][j] <= '0;
          a_pe_p1[i][j]   <= '0;
          b_pe_p1[i][j]   <= '0;
          acc_p1[i][j]    <= '0;
          flag_q[i][j]    <= 1'b0;
        end
      end
    end else begin
      for (int i = 0; i < MAX_DIM; i++) begin
        a_skew_p0[i][0] <= (vld_p0 && lane_en[i]) ? a_col_i[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        b_skew_p0[i][0] <= (vld_p0 && lane_en[i]) ? b_row_i[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int d = 1; d < MAX_DIM; d++) begin
          if (d <= i) begin
            a_skew_p0[i][d] <= a_skew_p0[i][d-1];
            b_skew_p0[i][d] <= b_skew_p0[i][d-1];
          end
        end
        for (int j = 0; j < MAX_DIM; j++) begin
          a_pe_p1[i][j] <= a_in[i][j];
          b_pe_p1[i][j] <= b_in[i][j];
          acc_p1[i][j]  <= sum_c[i][j];
          flag_q[i][j]  <= flag_q[i][j] | ovf_c[i][j];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < MAX_DIM; i++) begin
      for (int j = 0; j < MAX_DIM; j++) begin
        {ovf_c[i][j], sum_c[i][j]} = mac_add(acc_p1[i][j], a_in[i][j], b_in[i][j]);
      end
    end
  end

  for (genvar gi = 0; gi < MAX_DIM; gi++) begin : g_row
    assign lane_en[gi] = DIM_W'(gi) < n_q;
    for (genvar gj = 0; gj < MAX_DIM; gj++) begin : g_col
      if (gj == 0) begin : g_a_edge
        assign a_in[gi][gj] = a_skew_p0[gi][gi];
      end else begin : g_a_hop
        assign a_in[gi][gj] = a_pe_p1[gi][gj-1];
      end
      if (gi == 0) begin : g_b_edge
        assign b_in[gi][gj] = b_skew_p0[gj][gj];
      end else begin : g_b_hop
        assign b_in[gi][gj] = b_pe_p1[gi-1][gj];
      end
      assign mul_o[(gi*MAX_DIM+gj)*BUS_WIDTH +: BUS_WIDTH] = acc_p1[gi][gj];
      assign flags_o[gi*MAX_DIM+gj] = flag_q[gi][gj];
    end
  end
endmodule

// File: tb/tb_systolic_array_stream.sv
// Directed bench for systolic_array_stream: a 64/16 wrapping instance plus 32/16 wrapping and
// saturating instances for the overflow cases.
module tb_systolic_array_stream;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start0, valid0, ready0, busy0, fin0;
  logic [2:0]    dim0;
  logic [63:0]   a0, b0;
  logic [1023:0] mul0;
  logic [15:0]   flags0;

  logic          start1, valid1, ready1, busy1, fin1, ready2, busy2, fin2;
  logic [1:0]    dim1;
  logic [31:0]   a1, b1;
  logic [127:0]  mul1, mul2;
  logic [3:0]    flags1, flags2;

  systolic_array_stream #(.DATA_WIDTH(16), .BUS_WIDTH(64), .SATURATE(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start0), .dim_i(dim0), .a_col_i(a0), .b_row_i(b0),
    .valid_i(valid0), .ready_o(ready0), .mul_o(mul0), .flags_o(flags0), .busy_o(busy0),
    .finish_o(fin0));
  systolic_array_stream #(.DATA_WIDTH(16), .BUS_WIDTH(32), .SATURATE(0)) u_wrap (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .dim_i(dim1), .a_col_i(a1), .b_row_i(b1),
    .valid_i(valid1), .ready_o(ready1), .mul_o(mul1), .flags_o(flags1), .busy_o(busy1),
    .finish_o(fin1));
  systolic_array_stream #(.DATA_WIDTH(16), .BUS_WIDTH(32), .SATURATE(1)) u_sat (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .dim_i(dim1), .a_col_i(a1), .b_row_i(b1),
    .valid_i(valid1), .ready_o(ready2), .mul_o(mul2), .flags_o(flags2), .busy_o(busy2),
    .finish_o(fin2));

  int total = 0;
  int bad   = 0;
  int A [4][4];
  int B [4][4];
  int E [4][4];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int av, input int bv);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        A[i][j] = av;
        B[i][j] = bv;
        E[i][j] = 0;
      end
  endtask

  // 2x2 example in the top-left corner, 9s elsewhere to exercise masking.
  task automatic load_2x2;
    fill(9, 9);
    A[0][0] = 1; A[0][1] = 2; A[1][0] = 3; A[1][1] = 4;
    B[0][0] = 5; B[0][1] = 6; B[1][0] = 7; B[1][1] = 8;
    E[0][0] = 19; E[0][1] = 22; E[1][0] = 43; E[1][1] = 50;
  endtask

  task automatic drive_step0(input int k);
    for (int i = 0; i < 4; i++) begin
      a0[i*16 +: 16] = 16'(A[i][k]);
      b0[i*16 +: 16] = 16'(B[k][i]);
    end
  endtask

  task automatic run_op0(input int n, input int dimv, input bit bubble, output int cyc,
                         output logic rdy);
    start0 = 1'b1; dim0 = 3'(dimv);
    tick;
    start0 = 1'b0;
    rdy = ready0;
    cyc = 0;
    for (int k = 0; k < n; k++) begin
      if (bubble && k == 1) begin
        valid0 = 1'b0;
        tick; cyc++;
      end
      drive_step0(k);
      valid0 = 1'b1;
      tick; cyc++;
    end
    valid0 = 1'b0;
    while (fin0 !== 1'b1 && cyc < 200) begin
      tick; cyc++;
    end
  endtask

  task automatic run_op1(input logic [15:0] v, output int cyc);
    start1 = 1'b1; dim1 = 2'd2;
    tick;
    start1 = 1'b0;
    a1 = {v, v}; b1 = {v, v}; valid1 = 1'b1;
    cyc = 0;
    repeat (2) begin
      tick; cyc++;
    end
    valid1 = 1'b0;
    while (fin1 !== 1'b1 && cyc < 200) begin
      tick; cyc++;
    end
  endtask

  task automatic test_reset;
    total++; if (mul0 !== '0) begin bad++; $display("FAIL reset_mul0: got %0h want 0", mul0); end
    total++; if (flags0 !== '0) begin bad++; $display("FAIL reset_flags0: got %0h want 0", flags0); end
    total++; if ({ready0, busy0, fin0} !== 3'b000) begin bad++; $display("FAIL reset_ctrl0: got %b want 000", {ready0, busy0, fin0}); end
    total++; if ({mul1, mul2} !== '0) begin bad++; $display("FAIL reset_mul1: got %0h want 0", {mul1, mul2}); end
    total++; if ({ready1, busy1, fin1, ready2, busy2, fin2} !== 6'b0) begin bad++; $display("FAIL reset_ctrl1: got %b want 0", {ready1, busy1, fin1, ready2, busy2, fin2}); end
  endtask

  task automatic test_n4_all2;
    int cyc; logic rdy;
    fill(2, 2);
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) E[i][j] = 16;
    run_op0(4, 4, 1'b0, cyc, rdy);
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL n4_ready_feed: got %b want 1", rdy); end
    total++; if (cyc != 12) begin bad++; $display("FAIL n4_latency: got %0d want 12", cyc); end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        total++;
        if (mul0[(i*4+j)*64 +: 64] !== 64'(E[i][j])) begin
          bad++; $display("FAIL n4_c%0d%0d: got %0d want %0d", i, j, $signed(mul0[(i*4+j)*64 +: 64]), E[i][j]);
        end
      end
    total++; if (flags0 !== 16'h0) begin bad++; $display("FAIL n4_flags: got %h want 0", flags0); end
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL n4_busy_done: got %b want 0", busy0); end
    tick;
    total++; if (fin0 !== 1'b0) begin bad++; $display("FAIL n4_single_pulse: got %b want 0", fin0); end
    total++; if (mul0[63:0] !== 64'd16) begin bad++; $display("FAIL n4_hold: got %0d want 16", mul0[63:0]); end
  endtask

  task automatic test_bubble_n2;
    int cyc; logic rdy;
    load_2x2;
    run_op0(2, 2, 1'b1, cyc, rdy);
    total++; if (cyc != 7) begin bad++; $display("FAIL bubble_latency: got %0d want 7", cyc); end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        total++;
        if (mul0[(i*4+j)*64 +: 64] !== 64'(E[i][j])) begin
          bad++; $display("FAIL bubble_c%0d%0d: got %0d want %0d", i, j, $signed(mul0[(i*4+j)*64 +: 64]), E[i][j]);
        end
      end
    total++; if (flags0 !== 16'h0) begin bad++; $display("FAIL bubble_flags: got %h want 0", flags0); end
  endtask

  task automatic test_signed_n3;
    int cyc; logic rdy;
    fill(5, 5);
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) A[i][j] = (i == j) ? 1 : 0;
    B[0][0] = -1; B[0][1] = 2;  B[0][2] = -3;
    B[1][0] = 4;  B[1][1] = -5; B[1][2] = 6;
    B[2][0] = -7; B[2][1] = 8;  B[2][2] = -9;
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) E[i][j] = B[i][j];
    run_op0(3, 3, 1'b0, cyc, rdy);
    total++; if (cyc != 9) begin bad++; $display("FAIL n3_latency: got %0d want 9", cyc); end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        total++;
        if (mul0[(i*4+j)*64 +: 64] !== 64'(E[i][j])) begin
          bad++; $display("FAIL n3_c%0d%0d: got %0d want %0d", i, j, $signed(mul0[(i*4+j)*64 +: 64]), E[i][j]);
        end
      end
  endtask

  task automatic test_dim_zero;
    int cyc; logic rdy;
    fill(1, -1);
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) E[i][j] = -4;
    run_op0(4, 0, 1'b0, cyc, rdy);
    total++; if (cyc != 12) begin bad++; $display("FAIL dim0_latency: got %0d want 12", cyc); end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        total++;
        if (mul0[(i*4+j)*64 +: 64] !== 64'(E[i][j])) begin
          bad++; $display("FAIL dim0_c%0d%0d: got %0d want %0d", i, j, $signed(mul0[(i*4+j)*64 +: 64]), E[i][j]);
        end
      end
  endtask

  task automatic test_overflow;
    int cyc;
    // (-32768)^2 = 2^30, two steps reach 2^31: just past the 32-bit signed range.
    run_op1(16'h8000, cyc);
    total++; if (cyc != 6) begin bad++; $display("FAIL ovf_latency: got %0d want 6", cyc); end
    total++; if (fin2 !== 1'b1) begin bad++; $display("FAIL ovf_sat_finish: got %b want 1", fin2); end
    for (int s = 0; s < 4; s++) begin
      total++; if (mul1[s*32 +: 32] !== 32'h8000_0000) begin bad++; $display("FAIL ovf_wrap_s%0d: got %h want 80000000", s, mul1[s*32 +: 32]); end
      total++; if (mul2[s*32 +: 32] !== 32'h7FFF_FFFF) begin bad++; $display("FAIL ovf_sat_s%0d: got %h want 7fffffff", s, mul2[s*32 +: 32]); end
    end
    total++; if (flags1 !== 4'hF) begin bad++; $display("FAIL ovf_wrap_flags: got %h want f", flags1); end
    total++; if (flags2 !== 4'hF) begin bad++; $display("FAIL ovf_sat_flags: got %h want f", flags2); end
    // 2 * 0x3FFF0001 = 0x7FFE0002 stays in range; sticky flags cleared by the new start.
    run_op1(16'h7FFF, cyc);
    for (int s = 0; s < 4; s++) begin
      total++; if (mul1[s*32 +: 32] !== 32'h7FFE_0002) begin bad++; $display("FAIL max_wrap_s%0d: got %h want 7ffe0002", s, mul1[s*32 +: 32]); end
      total++; if (mul2[s*32 +: 32] !== 32'h7FFE_0002) begin bad++; $display("FAIL max_sat_s%0d: got %h want 7ffe0002", s, mul2[s*32 +: 32]); end
    end
    total++; if ({flags1, flags2} !== 8'h00) begin bad++; $display("FAIL max_flags: got %h want 00", {flags1, flags2}); end
  endtask

  task automatic test_restart;
    int cyc; int pulses; logic rdy;
    fill(2, 2);
    start0 = 1'b1; dim0 = 3'd4;
    tick;
    start0 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_step0(k); valid0 = 1'b1;
      tick;
    end
    valid0 = 1'b0;
    tick; tick;
    total++; if ({ready0, busy0} !== 2'b01) begin bad++; $display("FAIL restart_drain_ctrl: got %b want 01", {ready0, busy0}); end
    load_2x2;
    run_op0(2, 2, 1'b0, cyc, rdy);
    total++; if (cyc != 6) begin bad++; $display("FAIL restart_latency: got %0d want 6", cyc); end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        total++;
        if (mul0[(i*4+j)*64 +: 64] !== 64'(E[i][j])) begin
          bad++; $display("FAIL restart_c%0d%0d: got %0d want %0d", i, j, $signed(mul0[(i*4+j)*64 +: 64]), E[i][j]);
        end
      end
    pulses = 0;
    repeat (10) begin
      tick;
      if (fin0 === 1'b1) pulses++;
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL restart_extra_finish: got %0d want 0", pulses); end
  endtask

  task automatic test_async_reset;
    int cyc; logic rdy;
    fill(2, 2);
    start0 = 1'b1; dim0 = 3'd4;
    tick;
    start0 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive_step0(k); valid0 = 1'b1;
      tick;
    end
    total++; if (mul0[63:0] !== 64'd4) begin bad++; $display("FAIL pre_reset_acc00: got %0d want 4", mul0[63:0]); end
    total++; if (ready0 !== 1'b1) begin bad++; $display("FAIL pre_reset_ready: got %b want 1", ready0); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (mul0 !== '0) begin bad++; $display("FAIL async_mul: got %0h want 0", mul0); end
    total++; if ({flags0, ready0, busy0, fin0} !== 19'h0) begin bad++; $display("FAIL async_ctrl: got %h want 0", {flags0, ready0, busy0, fin0}); end
    valid0 = 1'b0;
    #1 rst_n = 1'b1;
    tick;
    load_2x2;
    run_op0(2, 2, 1'b0, cyc, rdy);
    total++; if (cyc != 6) begin bad++; $display("FAIL post_reset_latency: got %0d want 6", cyc); end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 3; j++) begin
        total++;
        if (mul0[(i*4+j)*64 +: 64] !== 64'(E[i][j])) begin
          bad++; $display("FAIL post_reset_c%0d%0d: got %0d want %0d", i, j, $signed(mul0[(i*4+j)*64 +: 64]), E[i][j]);
        end
      end
  endtask

  initial begin
    rst_n = 1'b0;
    start0 = 1'b0; valid0 = 1'b0; dim0 = '0; a0 = '0; b0 = '0;
    start1 = 1'b0; valid1 = 1'b0; dim1 = '0; a1 = '0; b1 = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    rst_n = 1'b1;
    tick;
    test_n4_all2;
    test_bubble_n2;
    test_signed_n3;
    test_dim_zero;
    test_overflow;
    test_restart;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
